// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and types for the fetch front end.
package riscv_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        IfidEmpty,
        IfidFull
    } ifid_state_e;

endpackage

// File: rtl/pc_reg.sv
// Fetch PC register with reset / redirect / advance / hold selection.
// FETCH_MISALIGN_TRAP_EN adds a registered misaligned-redirect pulse.
module pc_reg #(
    parameter int unsigned          XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]      RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic            misalign
);
    import riscv_pkg::*;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] target_aligned;

    assign target_aligned = redirect_pc & ~XLEN'(3);
    assign pc             = pc_q;

    // Redirect wins over advance; PC arithmetic wraps naturally at 2^XLEN.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= target_aligned;
        end else if (advance) begin
            pc_q <= pc_q + XLEN'(4);
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register plus the IF/ID pipeline register.
// Optional misaligned-redirect trap via FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int unsigned          XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]      RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] instr_addr,
    input  logic [XLEN-1:0] instr,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [XLEN-1:0] id_instr,
    output logic            misalign_trap
);
    import riscv_pkg::*;

    ifid_state_e     state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] id_pc_q;
    logic [XLEN-1:0] id_pc_plus4_q;
    logic [XLEN-1:0] id_instr_q;
    logic            accept;

    assign id_valid = (state_q == IfidFull);
    assign accept   = !id_valid || id_ready;

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (accept),
        .pc             (pc_q),
        .misalign       (misalign_trap)
    );

    assign instr_addr  = pc_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_instr    = id_instr_q;

    // A redirect only flushes; the payload keeps its last value until refilled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IfidEmpty;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            id_instr_q    <= XLEN'(NOP_INSTR);
        end else begin
            unique case (state_q)
                IfidEmpty: begin
                    if (!redirect_valid) begin
                        state_q       <= IfidFull;
                        id_pc_q       <= pc_q;
                        id_pc_plus4_q <= pc_q + XLEN'(4);
                        id_instr_q    <= instr;
                    end
                end
                IfidFull: begin
                    if (redirect_valid) begin
                        state_q <= IfidEmpty;
                    end else if (id_ready) begin
                        id_pc_q       <= pc_q;
                        id_pc_plus4_q <= pc_q + XLEN'(4);
                        id_instr_q    <= instr;
                    end
                end
                default: state_q <= IfidEmpty;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a handshake scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        misalign_trap;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] plus4;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_addr     (instr_addr),
        .instr          (instr),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr),
        .misalign_trap  (misalign_trap)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    // Instruction memory: word k holds 0x1000_0000 + k.
    assign instr = mem_word(instr_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic [31:0] addr);
        exp_t e;
        e.pc    = addr;
        e.ins   = mem_word(addr);
        e.plus4 = addr + 32'd4;
        sb.push_back(e);
    endtask

    // Compare any handshake against the scoreboard, then advance one clock.
    task automatic cycle();
        exp_t e;
        if (id_valid && id_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_handshake", id_pc, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                chk("sb_id_pc", id_pc, e.pc);
                chk("sb_id_instr", id_instr, e.ins);
                chk("sb_id_pc_plus4", id_pc_plus4, e.plus4);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_trap;
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_trap = 1'b1;
`else
        exp_trap = 1'b0;
`endif
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        cycle();
        cycle();
        chk("rst_instr_addr", instr_addr, 32'h0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, 32'h0000_0013);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'h0);
        chk("rst_misalign", {31'd0, misalign_trap}, 32'd0);

        // Streaming fetch from reset.
        reset = 1'b0;
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        cycle();
        chk("stream_valid", {31'd0, id_valid}, 32'd1);
        chk("stream_pc0", id_pc, 32'h0);
        cycle();
        chk("stream_pc4", id_pc, 32'h4);
        cycle();
        chk("stream_pc8", id_pc, 32'h8);
        chk("stream_instr8", id_instr, 32'h1000_0002);

        // Stall for three cycles.
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_id_pc", id_pc, 32'h8);
            chk("stall_id_instr", id_instr, 32'h1000_0002);
            chk("stall_instr_addr", instr_addr, 32'hC);
        end
        id_ready = 1'b1;
        cycle();
        chk("resume_id_pc", id_pc, 32'hC);

        // Redirect while stalled.
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cycle();
        chk("redir_flush", {31'd0, id_valid}, 32'd0);
        chk("redir_addr", instr_addr, 32'h40);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        push_exp(32'h40);
        cycle();
        chk("redir_valid", {31'd0, id_valid}, 32'd1);
        chk("redir_id_pc", id_pc, 32'h40);

        // Wraparound at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        cycle();
        chk("wrap_addr", instr_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0);
        cycle();
        chk("wrap_next_addr", instr_addr, 32'h0);
        chk("wrap_plus4", id_pc_plus4, 32'h0);
        cycle();
        chk("wrap_id_pc", id_pc, 32'h0);
        cycle();

        // Back-to-back redirects: last one wins, no valid in between.
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cycle();
        chk("b2b_valid0", {31'd0, id_valid}, 32'd0);
        chk("b2b_addr0", instr_addr, 32'h100);
        redirect_pc = 32'h200;
        cycle();
        chk("b2b_valid1", {31'd0, id_valid}, 32'd0);
        chk("b2b_addr1", instr_addr, 32'h200);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        push_exp(32'h200);
        cycle();
        chk("b2b_id_pc", id_pc, 32'h200);
        cycle();

        // Misaligned redirect.
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        cycle();
        chk("mis_trap", {31'd0, misalign_trap}, {31'd0, exp_trap});
        chk("mis_addr", instr_addr, 32'h40);
        chk("mis_valid", {31'd0, id_valid}, 32'd0);
        redirect_valid = 1'b0;
        cycle();
        chk("mis_trap_pulse", {31'd0, misalign_trap}, 32'd0);
        chk("mis_id_pc", id_pc, 32'h40);

        // Reset during a stall, coincident with a redirect.
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        cycle();
        chk("rr_addr", instr_addr, 32'h0);
        chk("rr_valid", {31'd0, id_valid}, 32'd0);
        chk("rr_instr", id_instr, 32'h0000_0013);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        push_exp(32'h0);
        cycle();
        chk("rr_resume_pc", id_pc, 32'h0);
        cycle();
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
